// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage: FSM state
// encodings, the NOP instruction, the PC step and a word-alignment helper.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DRAIN = 2'b11
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [31:0] PC_STEP       = 32'd4;
    localparam logic [31:0] WORD_MASK     = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_fetch_out_reg.sv
// Fetch output register (valid/instr/pc) with flush > load > consume priority.
module fetch_out_reg
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        consume,
    input  logic        flush,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    logic        valid_d, valid_q;
    logic [31:0] instr_d, instr_q;
    logic [31:0] pc_d, pc_q;

    // Next-state for the output register; a flush keeps the old pc for debug visibility.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            pc_d    = load_pc;
        end else if (consume) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= RESET_PC;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_pc    = pc_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// RV32 instruction-fetch stage: PC, one-outstanding imem request FSM, redirect/drain.
// Optional misaligned-redirect trap is enabled with `define FETCH_MISALIGN_TRAP_EN.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign_trap
`endif
);

    fetch_state_e state_d, state_q;
    logic [31:0]  pc_d, pc_q;
    logic [31:0]  req_pc_d, req_pc_q;
    logic         req_fire_s;
    logic         out_load_s;
    logic         out_consume_s;
    logic [31:0]  redir_target_s;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic park_d, park_q;
    logic trap_d, trap_q;
    logic redir_misaligned_s;

    assign redir_misaligned_s = (redirect_pc[1:0] != 2'b00);
    assign imem_req_valid     = (state_q == ST_REQ) && !(if_valid && stall) && !park_q;
    assign misalign_trap      = trap_q;
`else
    assign imem_req_valid     = (state_q == ST_REQ) && !(if_valid && stall);
`endif

    assign redir_target_s = word_align(redirect_pc);
    assign req_fire_s     = imem_req_valid && imem_req_ready;
    assign imem_req_addr  = word_align(pc_q);
    assign out_consume_s  = if_valid && !stall;

    // FSM next-state and PC update; a redirect overrides the normal flow.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        out_load_s = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        park_d     = park_q;
        trap_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (req_fire_s) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + PC_STEP;
                    state_d  = ST_WAIT;
                end else begin
                    state_d  = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    out_load_s = 1'b1;
                    state_d    = ST_REQ;
                end else begin
                    state_d    = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (redirect_valid) begin
            out_load_s = 1'b0;
            // A response landing in DRAIN is the one being drained, so leave DRAIN then.
            case (state_q)
                ST_REQ:   state_d = req_fire_s ? ST_DRAIN : ST_REQ;
                ST_WAIT:  state_d = imem_rsp_valid ? ST_REQ : ST_DRAIN;
                ST_DRAIN: state_d = imem_rsp_valid ? ST_REQ : ST_DRAIN;
                default:  state_d = ST_REQ;
            endcase
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redir_misaligned_s) begin
                pc_d   = pc_q;
                park_d = 1'b1;
                trap_d = 1'b1;
            end else begin
                pc_d   = redir_target_s;
                park_d = 1'b0;
            end
`else
            pc_d = redir_target_s;
`endif
        end else begin
            out_load_s = out_load_s;
        end
    end

    // FSM and PC state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= word_align(RESET_PC);
            req_pc_q <= word_align(RESET_PC);
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Park flag and one-cycle trap pulse for rejected misaligned redirects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            park_q <= 1'b0;
            trap_q <= 1'b0;
        end else begin
            park_q <= park_d;
            trap_q <= trap_d;
        end
    end
`endif

    fetch_out_reg #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (out_load_s),
        .consume    (out_consume_s),
        .flush      (redirect_valid),
        .load_instr (imem_rsp_data),
        .load_pc    (req_pc_q),
        .out_valid  (if_valid),
        .out_instr  (if_instr),
        .out_pc     (if_pc)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed, table-driven bench for pc_fetch_unit plus a wrap-around instance.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_w = 1'b1;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;

    logic        req_valid, w_req_valid;
    logic [31:0] req_addr, w_req_addr;
    logic        if_valid, w_if_valid;
    logic [31:0] if_instr, w_if_instr;
    logic [31:0] if_pc, w_if_pc;
    logic        trap;
    logic        w_trap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .misalign_trap(trap)
`endif
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst_w),
        .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .if_valid(w_if_valid), .if_instr(w_if_instr), .if_pc(w_if_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .misalign_trap(w_trap)
`endif
    );

`ifndef FETCH_MISALIGN_TRAP_EN
    assign trap   = 1'b0;
    assign w_trap = 1'b0;
`endif

    typedef struct {
        logic        ready;
        logic        rsp_v;
        logic [31:0] rsp_d;
        logic        rd_v;
        logic [31:0] rd_pc;
        logic        stl;
        logic        e_req_v;
        logic [31:0] e_addr;
        logic        e_if_v;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_trap;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rd,
                                input logic dv, input logic [31:0] dpc, input logic st,
                                input logic erv, input logic [31:0] ea, input logic eiv,
                                input logic [31:0] ei, input logic [31:0] ep, input logic et);
        vec_t v;
        v.ready = rdy; v.rsp_v = rv; v.rsp_d = rd; v.rd_v = dv; v.rd_pc = dpc; v.stl = st;
        v.e_req_v = erv; v.e_addr = ea; v.e_if_v = eiv; v.e_instr = ei; v.e_pc = ep; v.e_trap = et;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        // ready rsp_v rsp_d      rd_v rd_pc  stall | req_v addr     if_v instr        pc       trap
        vecs[0]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b0, 32'h000, 1'b0, NOP,          32'h000, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b1, 32'h000, 1'b0, NOP,          32'h000, 1'b0);
        vecs[2]  = mk(1'b1, 1'b1, 32'h00100093, 1'b0, 32'h0,   1'b0, 1'b0, 32'h004, 1'b0, NOP,          32'h000, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b1, 32'h004, 1'b1, 32'h00100093, 32'h000, 1'b0);
        vecs[4]  = mk(1'b1, 1'b1, 32'h00200093, 1'b0, 32'h0,   1'b0, 1'b0, 32'h008, 1'b0, 32'h00100093, 32'h000, 1'b0);
        vecs[5]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b1, 32'h008, 1'b1, 32'h00200093, 32'h004, 1'b0);
        vecs[6]  = mk(1'b1, 1'b1, 32'h00500093, 1'b0, 32'h0,   1'b0, 1'b0, 32'h00C, 1'b0, 32'h00200093, 32'h004, 1'b0);
        vecs[7]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 1'b0, 32'h00C, 1'b1, 32'h00500093, 32'h008, 1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 1'b0, 32'h00C, 1'b1, 32'h00500093, 32'h008, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b1, 32'h00C, 1'b1, 32'h00500093, 32'h008, 1'b0);
        vecs[10] = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h100, 1'b0, 1'b0, 32'h010, 1'b0, 32'h00500093, 32'h008, 1'b0);
        vecs[11] = mk(1'b1, 1'b1, 32'h00C00093, 1'b0, 32'h0,   1'b0, 1'b0, 32'h100, 1'b0, NOP,          32'h008, 1'b0);
        vecs[12] = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b1, 32'h100, 1'b0, NOP,          32'h008, 1'b0);
        vecs[13] = mk(1'b1, 1'b1, 32'h10000093, 1'b0, 32'h0,   1'b0, 1'b0, 32'h104, 1'b0, NOP,          32'h008, 1'b0);
        vecs[14] = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b1, 32'h104, 1'b1, 32'h10000093, 32'h100, 1'b0);
        vecs[15] = mk(1'b1, 1'b1, 32'h10400093, 1'b1, 32'h200, 1'b0, 1'b0, 32'h108, 1'b0, 32'h10000093, 32'h100, 1'b0);
        vecs[16] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b1, 32'h200, 1'b0, NOP,          32'h100, 1'b0);
        vecs[17] = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h300, 1'b0, 1'b1, 32'h200, 1'b0, NOP,          32'h100, 1'b0);
        vecs[18] = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b0, 32'h300, 1'b0, NOP,          32'h100, 1'b0);
        vecs[19] = mk(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,   1'b0, 1'b0, 32'h300, 1'b0, NOP,          32'h100, 1'b0);
        vecs[20] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h102, 1'b0, 1'b1, 32'h300, 1'b0, NOP,          32'h100, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
        vecs[21] = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b0, 32'h300, 1'b0, NOP,          32'h100, 1'b1);
`else
        vecs[21] = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b1, 32'h100, 1'b0, NOP,          32'h100, 1'b0);
`endif

        // Reset state while rst is held.
        @(negedge clk);
        #1;
        chk("rst_req_valid", 0, {31'b0, req_valid}, 32'h0);
        chk("rst_if_valid",  0, {31'b0, if_valid},  32'h0);
        chk("rst_if_instr",  0, if_instr, NOP);
        chk("rst_if_pc",     0, if_pc,    32'h0);
        chk("rst_trap",      0, {31'b0, trap}, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            if (i == 0) rst = 1'b0;
            imem_req_ready = vecs[i].ready;
            imem_rsp_valid = vecs[i].rsp_v;
            imem_rsp_data  = vecs[i].rsp_d;
            redirect_valid = vecs[i].rd_v;
            redirect_pc    = vecs[i].rd_pc;
            stall          = vecs[i].stl;
            #1;
            chk("req_valid", i, {31'b0, req_valid}, {31'b0, vecs[i].e_req_v});
            chk("req_addr",  i, req_addr, vecs[i].e_addr);
            chk("addr_lsb",  i, {30'b0, req_addr[1:0]}, 32'h0);
            chk("if_valid",  i, {31'b0, if_valid}, {31'b0, vecs[i].e_if_v});
            chk("if_instr",  i, if_instr, vecs[i].e_instr);
            chk("if_pc",     i, if_pc, vecs[i].e_pc);
            chk("trap",      i, {31'b0, trap}, {31'b0, vecs[i].e_trap});
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        // Parked after the misaligned redirect: stay silent until an aligned redirect.
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #1;
        chk("park_req_valid", 0, {31'b0, req_valid}, 32'h0);
        chk("park_trap_low",  0, {31'b0, trap}, 32'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("unpark_req_valid", 0, {31'b0, req_valid}, 32'h1);
        chk("unpark_req_addr",  0, req_addr, 32'h200);
`endif

        // PC wrap on the second instance.
        @(negedge clk);
        rst_w          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        #1;
        chk("wrap_idle_req", 0, {31'b0, w_req_valid}, 32'h0);
        @(negedge clk);
        #1;
        chk("wrap_req_valid0", 0, {31'b0, w_req_valid}, 32'h1);
        chk("wrap_req_addr0",  0, w_req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h00A00093;
        #1;
        chk("wrap_wait_req", 0, {31'b0, w_req_valid}, 32'h0);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        #1;
        chk("wrap_req_valid1", 0, {31'b0, w_req_valid}, 32'h1);
        chk("wrap_req_addr1",  0, w_req_addr, 32'h0);
        chk("wrap_if_pc",      0, w_if_pc, 32'hFFFF_FFFC);
        chk("wrap_if_instr",   0, w_if_instr, 32'h00A00093);
        chk("wrap_if_valid",   0, {31'b0, w_if_valid}, 32'h1);
        chk("wrap_trap",       0, {31'b0, w_trap}, 32'h0);

        // Asynchronous reset takes effect without a clock edge.
        @(negedge clk);
        #1;
        rst_w = 1'b1;
        #1;
        chk("async_if_valid", 0, {31'b0, w_if_valid}, 32'h0);
        chk("async_if_instr", 0, w_if_instr, NOP);
        chk("async_if_pc",    0, w_if_pc, 32'hFFFF_FFFC);
        chk("async_req_valid", 0, {31'b0, w_req_valid}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
